// File: rtl/ne_term_wire_bist_if.sv
// Bus between the termination-tile BIST engine and its controller/loopback.
// The controller drives the run controls and the sensed wires. The engine
// drives the wire patterns and the run status/results.
interface ne_term_wire_bist_if;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [35:0] n_drive;
  logic [35:0] s_sense;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_count;
  logic [15:0] first_fail_idx;
  logic [35:0] first_fail_bits;

  modport master (
    output start, stop, mode, s_sense,
    input  n_drive, busy, done, pass, err_count, first_fail_idx, first_fail_bits
  );

  modport slave (
    input  start, stop, mode, s_sense,
    output n_drive, busy, done, pass, err_count, first_fail_idx, first_fail_bits
  );
endinterface

// File: rtl/ne_term_wire_bist.sv
// North-east termination tile wire self-test.
// Drives N1END/N2MID/N2END/N4END with a pattern. It checks that S1BEG/S2BEG/
// S2BEGb/S4BEG return the per-group bit-reversed loopback LAT cycles later.
module ne_term_wire_bist #(
  parameter int          LAT  = 2,
  parameter int          NVEC = 256,
  parameter logic [35:0] SEED = 36'h5A5A5A5A5
) (
  input logic                  UserCLK,
  input logic                  resetn,
  ne_term_wire_bist_if.slave   bist
);

  localparam logic [35:0] SEED_EFF   = (SEED == 36'h0) ? 36'h1 : SEED;
  localparam logic [15:0] LAST_K     = 16'(NVEC - 1);
  localparam logic [3:0]  DRAIN_LAST = 4'(LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // Tile loopback: each wire group comes back with its bit order reversed.
  function automatic logic [35:0] rev_groups(input logic [35:0] d);
    logic [35:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)  r[i]      = d[3 - i];
    for (int i = 0; i < 8; i++)  r[4 + i]  = d[11 - i];
    for (int i = 0; i < 8; i++)  r[12 + i] = d[19 - i];
    for (int i = 0; i < 16; i++) r[20 + i] = d[35 - i];
    return r;
  endfunction

  // Fibonacci x^36 + x^25 + 1, shifting toward the MSB.
  function automatic logic [35:0] lfsr_next(input logic [35:0] l);
    return {l[34:0], l[35] ^ l[24]};
  endfunction

  // Pattern generator. wpos tracks k mod 36 and odd tracks k parity.
  function automatic logic [35:0] vec_of(input logic [1:0] m, input logic [5:0] wpos,
                                         input logic odd, input logic [35:0] l);
    logic [35:0] v;
    case (m)
      2'd0:    v = 36'h1 << wpos;
      2'd1:    v = ~(36'h1 << wpos);
      2'd2:    v = l;
      default: v = odd ? {36{1'b1}} : 36'h0;
    endcase
    return v;
  endfunction

  state_t                 r_state;
  logic [1:0]             r_mode;
  logic [15:0]            r_k;
  logic [5:0]             r_wpos;
  logic [35:0]            r_lfsr;
  logic [35:0]            r_ndrive;
  logic [3:0]             r_drain_cnt;
  logic                   r_busy;
  logic                   r_done;
  logic [15:0]            r_err;
  logic [15:0]            r_ff_idx;
  logic [35:0]            r_ff_bits;
  logic [15:0]            r_cmp_idx;
  logic [LAT-1:0]         r_vld_pipe;
  logic [LAT-1:0][35:0]   r_exp_pipe;

  logic        w_busy_st;
  logic        w_flush;
  logic        w_cmp_vld;
  logic [35:0] w_diff;
  logic        w_miss;
  logic [5:0]  w_wpos_nxt;
  logic [35:0] w_lfsr_nxt;
  logic [35:0] w_vec_nxt;

  assign w_busy_st  = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_flush    = w_busy_st && bist.stop;
  assign w_cmp_vld  = r_vld_pipe[LAT-1];
  assign w_diff     = r_exp_pipe[LAT-1] ^ bist.s_sense;
  assign w_miss     = w_cmp_vld && (|w_diff);
  assign w_wpos_nxt = (r_wpos == 6'd35) ? 6'd0 : r_wpos + 6'd1;
  assign w_lfsr_nxt = lfsr_next(r_lfsr);
  assign w_vec_nxt  = vec_of(r_mode, w_wpos_nxt, ~r_k[0], w_lfsr_nxt);

  // Expected-value delay line. Each RUN vector enters it, and a stop empties it.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      r_vld_pipe <= '0;
      r_exp_pipe <= '0;
    end else if (w_flush) begin
      r_vld_pipe <= '0;
      r_exp_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= (r_state == S_RUN);
      r_exp_pipe[0] <= rev_groups(r_ndrive);
      for (int i = 1; i < LAT; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_exp_pipe[i] <= r_exp_pipe[i-1];
      end
    end
  end

  // Run sequencer, pattern drive and result accumulation.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_mode      <= 2'd0;
      r_k         <= '0;
      r_wpos      <= '0;
      r_lfsr      <= SEED_EFF;
      r_ndrive    <= '0;
      r_drain_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= '0;
      r_ff_idx    <= '0;
      r_ff_bits   <= '0;
      r_cmp_idx   <= '0;
    end else begin
      // A compare that is already at the line output still counts in the cycle a stop arrives.
      if (w_cmp_vld) r_cmp_idx <= r_cmp_idx + 16'd1;
      if (w_miss) begin
        if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
        if (r_err == 16'h0) begin
          r_ff_idx  <= r_cmp_idx;
          r_ff_bits <= w_diff;
        end
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bist.start && !bist.stop) begin
            r_state   <= S_RUN;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= '0;
            r_ff_idx  <= '0;
            r_ff_bits <= '0;
            r_cmp_idx <= '0;
            r_k       <= '0;
            r_wpos    <= '0;
            r_lfsr    <= SEED_EFF;
            r_mode    <= bist.mode;
            r_ndrive  <= vec_of(bist.mode, 6'd0, 1'b0, SEED_EFF);
          end
        end
        S_RUN: begin
          if (bist.stop) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_ndrive <= '0;
          end else if (r_k == LAST_K) begin
            r_state     <= S_DRAIN;
            r_ndrive    <= '0;
            r_drain_cnt <= DRAIN_LAST;
          end else begin
            r_k      <= r_k + 16'd1;
            r_wpos   <= w_wpos_nxt;
            r_lfsr   <= w_lfsr_nxt;
            r_ndrive <= w_vec_nxt;
          end
        end
        default: begin // S_DRAIN
          if (bist.stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_drain_cnt == 4'd0) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - 4'd1;
          end
        end
      endcase
    end
  end

  assign bist.n_drive         = r_ndrive;
  assign bist.busy            = r_busy;
  assign bist.done            = r_done;
  assign bist.pass            = r_done && (r_err == 16'h0);
  assign bist.err_count       = r_err;
  assign bist.first_fail_idx  = r_ff_idx;
  assign bist.first_fail_bits = r_ff_bits;

endmodule

// File: tb/tb_ne_term_wire_bist.sv
// Directed bench for ne_term_wire_bist. It uses four engines with different
// NVEC. Each engine has its own LAT=2 loopback and its own planted wire fault.
module tb_ne_term_wire_bist;
  logic gclk = 1'b0;
  logic grst_n;
  always #5 gclk = ~gclk;

  ne_term_wire_bist_if ifa();
  ne_term_wire_bist_if ifb();
  ne_term_wire_bist_if ifc();
  ne_term_wire_bist_if ifd();

  ne_term_wire_bist #(.LAT(2), .NVEC(8))     u_a (.UserCLK(gclk), .resetn(grst_n), .bist(ifa));
  ne_term_wire_bist #(.LAT(2), .NVEC(36))    u_b (.UserCLK(gclk), .resetn(grst_n), .bist(ifb));
  ne_term_wire_bist #(.LAT(2), .NVEC(4))     u_c (.UserCLK(gclk), .resetn(grst_n), .bist(ifc));
  ne_term_wire_bist #(.LAT(2), .NVEC(65535)) u_d (.UserCLK(gclk), .resetn(grst_n), .bist(ifd));

  logic        st [4];
  logic        sp [4];
  logic [1:0]  md [4];
  logic [35:0] nd [4];
  logic        bs [4];
  logic        dn [4];
  logic        ps [4];
  logic [15:0] ec [4];
  logic [15:0] fi [4];
  logic [35:0] fb [4];

  assign ifa.start = st[0]; assign ifa.stop = sp[0]; assign ifa.mode = md[0];
  assign ifb.start = st[1]; assign ifb.stop = sp[1]; assign ifb.mode = md[1];
  assign ifc.start = st[2]; assign ifc.stop = sp[2]; assign ifc.mode = md[2];
  assign ifd.start = st[3]; assign ifd.stop = sp[3]; assign ifd.mode = md[3];

  assign nd[0] = ifa.n_drive; assign bs[0] = ifa.busy; assign dn[0] = ifa.done; assign ps[0] = ifa.pass;
  assign ec[0] = ifa.err_count; assign fi[0] = ifa.first_fail_idx; assign fb[0] = ifa.first_fail_bits;
  assign nd[1] = ifb.n_drive; assign bs[1] = ifb.busy; assign dn[1] = ifb.done; assign ps[1] = ifb.pass;
  assign ec[1] = ifb.err_count; assign fi[1] = ifb.first_fail_idx; assign fb[1] = ifb.first_fail_bits;
  assign nd[2] = ifc.n_drive; assign bs[2] = ifc.busy; assign dn[2] = ifc.done; assign ps[2] = ifc.pass;
  assign ec[2] = ifc.err_count; assign fi[2] = ifc.first_fail_idx; assign fb[2] = ifc.first_fail_bits;
  assign nd[3] = ifd.n_drive; assign bs[3] = ifd.busy; assign dn[3] = ifd.done; assign ps[3] = ifd.pass;
  assign ec[3] = ifd.err_count; assign fi[3] = ifd.first_fail_idx; assign fb[3] = ifd.first_fail_bits;

  // Reference tile mapping: drive bit b in a group [base, base+w) lands at the mirrored position.
  function automatic logic [35:0] tile_map(input logic [35:0] d);
    logic [35:0] r;
    int base, w;
    r = '0;
    for (int b = 0; b < 36; b++) begin
      if (b < 4)       begin base = 0;  w = 4;  end
      else if (b < 12) begin base = 4;  w = 8;  end
      else if (b < 20) begin base = 12; w = 8;  end
      else             begin base = 20; w = 16; end
      r[base + w - 1 - (b - base)] = d[b];
    end
    return r;
  endfunction

  // Two-register loopback per engine. The faults are: A clean, B S4BEG3 stuck 0,
  // C S2BEG0/1 swapped, and D S1BEG0 inverted.
  logic [35:0] a_d1, a_d2, b_d1, b_d2, c_d1, c_d2, d_d1, d_d2;
  always_ff @(posedge gclk) begin
    a_d1 <= tile_map(ifa.n_drive); a_d2 <= a_d1;
    b_d1 <= tile_map(ifb.n_drive); b_d2 <= b_d1;
    c_d1 <= tile_map(ifc.n_drive); c_d2 <= c_d1;
    d_d1 <= tile_map(ifd.n_drive); d_d2 <= d_d1;
  end
  assign ifa.s_sense = a_d2;
  assign ifb.s_sense = b_d2 & ~(36'h1 << 23);
  assign ifc.s_sense = {c_d2[35:6], c_d2[4], c_d2[5], c_d2[3:0]};
  assign ifd.s_sense = d_d2 ^ 36'h1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge gclk);
  endtask

  // After this returns, the engine is in its first RUN cycle and is driving vector 0.
  task automatic start_run(input int w, input logic [1:0] m);
    md[w] = m;
    st[w] = 1'b1;
    tick();
    st[w] = 1'b0;
  endtask

  task automatic wait_done(input int w, input int budget, input string tag);
    int n;
    n = 0;
    while (!dn[w] && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 64'(dn[w]), 64'd1);
  endtask

  initial begin
    int          nb;
    int          cnt;
    int          fidx;
    logic [35:0] lf;

    for (int w = 0; w < 4; w++) begin st[w] = 0; sp[w] = 0; md[w] = 0; end
    grst_n = 1'b0;
    repeat (3) tick();
    for (int w = 0; w < 4; w++) begin
      chk("rst_ndrive", 64'(nd[w]), 64'd0);
      chk("rst_busy",   64'(bs[w]), 64'd0);
      chk("rst_done",   64'(dn[w]), 64'd0);
      chk("rst_err",    64'(ec[w]), 64'd0);
    end
    grst_n = 1'b1;
    tick();

    // start together with stop: the engine stays idle
    st[0] = 1; sp[0] = 1;
    tick();
    st[0] = 0; sp[0] = 0;
    tick();
    chk("ss_busy",   64'(bs[0]), 64'd0);
    chk("ss_ndrive", 64'(nd[0]), 64'd0);

    // A: walking one on an ideal loopback
    start_run(0, 2'd0);
    nb = 0;
    for (int k = 0; k < 8; k++) begin
      chk("A_vec", 64'(nd[0]), 64'(36'h1 << k));
      if (bs[0]) nb++;
      tick();
    end
    while (bs[0] && nb < 100) begin
      nb++;
      tick();
    end
    chk("A_busycyc", 64'(nb), 64'd10);
    chk("A_done",    64'(dn[0]), 64'd1);
    chk("A_pass",    64'(ps[0]), 64'd1);
    chk("A_err",     64'(ec[0]), 64'd0);
    chk("A_ndrive0", 64'(nd[0]), 64'd0);

    // B: walking zero with S4BEG3 stuck 0. A start pulse during the run is ignored.
    start_run(1, 2'd1);
    repeat (5) tick();
    st[1] = 1; tick(); st[1] = 0;
    wait_done(1, 100, "B_done");
    chk("B_err",   64'(ec[1]), 64'd35);
    chk("B_fidx",  64'(fi[1]), 64'd0);
    chk("B_fbits", 64'(fb[1]), 64'h000800000);
    chk("B_pass",  64'(ps[1]), 64'd0);

    // C: LFSR with S2BEG0/1 swapped. The reference counts vectors with N2MID7 != N2MID6.
    start_run(2, 2'd2);
    lf = 36'h5A5A5A5A5;
    cnt = 0;
    fidx = 0;
    for (int k = 0; k < 4; k++) begin
      chk("C_vec", 64'(nd[2]), 64'(lf));
      if (lf[11] != lf[10]) begin
        if (cnt == 0) fidx = k;
        cnt++;
      end
      lf = {lf[34:0], lf[35] ^ lf[24]};
      tick();
    end
    wait_done(2, 50, "C_done");
    chk("C_err",   64'(ec[2]), 64'(cnt));
    chk("C_fidx",  64'(fi[2]), 64'(fidx));
    chk("C_fbits", 64'(fb[2]), (cnt != 0) ? 64'h30 : 64'h0);
    chk("C_pass",  64'(ps[2]), (cnt == 0) ? 64'd1 : 64'd0);

    // B: stop in the third RUN cycle, then a clean full run
    start_run(1, 2'd0);
    tick(); tick();
    sp[1] = 1; tick(); sp[1] = 0;
    chk("stop_busy",   64'(bs[1]), 64'd0);
    chk("stop_done",   64'(dn[1]), 64'd0);
    chk("stop_ndrive", 64'(nd[1]), 64'd0);
    tick();
    chk("stop_idle", 64'(bs[1]), 64'd0);
    start_run(1, 2'd1);
    wait_done(1, 100, "B2_done");
    chk("B2_err",  64'(ec[1]), 64'd35);
    chk("B2_fidx", 64'(fi[1]), 64'd0);

    // B: reset in the first DRAIN cycle
    start_run(1, 2'd1);
    repeat (36) tick();
    chk("drn_busy",   64'(bs[1]), 64'd1);
    chk("drn_ndrive", 64'(nd[1]), 64'd0);
    grst_n = 1'b0;
    #1;
    chk("mrst_busy", 64'(bs[1]), 64'd0);
    chk("mrst_err",  64'(ec[1]), 64'd0);
    chk("mrst_fidx", 64'(fi[1]), 64'd0);
    chk("mrst_done", 64'(dn[1]), 64'd0);
    tick();
    grst_n = 1'b1;
    tick();
    // With walking one, S4BEG3 expects 1 only at k=32.
    start_run(1, 2'd0);
    wait_done(1, 100, "B3_done");
    chk("B3_err",   64'(ec[1]), 64'd1);
    chk("B3_fidx",  64'(fi[1]), 64'd32);
    chk("B3_fbits", 64'(fb[1]), 64'h000800000);

    // D: every vector of a 65535-vector alternating run fails
    start_run(3, 2'd3);
    chk("D_vec0", 64'(nd[3]), 64'd0);
    tick();
    chk("D_vec1", 64'(nd[3]), 64'hFFFFFFFFF);
    wait_done(3, 70000, "D_done");
    chk("D_err",   64'(ec[3]), 64'hFFFF);
    chk("D_fidx",  64'(fi[3]), 64'd0);
    chk("D_fbits", 64'(fb[3]), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ne_term_wire_bist.md
Name: ne_term_wire_bist

Overview:
- Self-test engine that sits directly upstream of the north-east termination tile's switch matrix.
- Drives the tile's north-side END/MID wire inputs (N1END, N2MID, N2END, N4END) with test patterns.
- Checks that the south-side BEG outputs (S1BEG, S2BEG, S2BEGb, S4BEG) return the fixed per-group bit-reversed loopback after a known pipeline latency.
- Used for post-tapeout validation of termination routing; reports pass/fail, an error count and the first failing vector.

Parameters:
- LAT, 2, cycles from n_drive change to the matching s_sense value at the checker input (external wire/register delay); legal 1..15.
- NVEC, 256, vectors per run; legal 1..65535.
- SEED, 36'h5A5A5A5A5, LFSR seed; a zero seed is replaced by 36'h1.

Ports:
- UserCLK  input  1  fabric user clock; all state on rising edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle run request; sampled in IDLE or DONE only.
- stop  input  1  abort request; takes effect from any busy state.
- mode  input  2  pattern: 0 walking-one, 1 walking-zero, 2 LFSR, 3 alternating all-0/all-1 (first vector all-0).
- n_drive  output  36  packed drive: [3:0] N1END0..3, [11:4] N2MID0..7, [19:12] N2END0..7, [35:20] N4END0..15.
- s_sense  input  36  packed sense: [3:0] S1BEG0..3, [11:4] S2BEG0..7, [19:12] S2BEGb0..7, [35:20] S4BEG0..15.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  high in DONE.
- pass  output  1  done and err_count==0.
- err_count  output  16  count of mismatching vectors; saturates at 16'hFFFF.
- first_fail_idx  output  16  index of the first mismatching vector.
- first_fail_bits  output  36  XOR of expected and sensed values for the first mismatch.

Behaviour:
- Reset: async, all outputs 0, state IDLE, LFSR=SEED (or 1 if SEED is 0), expected-value delay line cleared.
- Expected mapping: expected = R(drive). R reverses bit order within each group independently:
  - S1BEG[i] = N1END[3-i]
  - S2BEG[i] = N2MID[7-i]
  - S2BEGb[i] = N2END[7-i]
  - S4BEG[i] = N4END[15-i]
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE to RUN:
  - Transition on start with stop low.
  - On entry: clear err_count, first_fail_*, done; reload LFSR; vector index k=0.
  - In the cycle after start, n_drive = vector 0.
- RUN:
  - One vector per cycle; k increments each cycle.
  - After the vector with k=NVEC-1 is driven, go to DRAIN.
- DRAIN:
  - Lasts LAT cycles; n_drive = 0.
  - Then go to DONE (done=1, busy=0).
- Pattern for vector k:
  - walking-one: 1<<(k mod 36).
  - walking-zero: ~(1<<(k mod 36)).
  - LFSR: Fibonacci x^36+x^25+1; vector 0 = seed value, advances once per vector.
  - alternating: k even -> 0, k odd -> all ones.
- Compare pipeline:
  - R(n_drive) and a valid bit are pushed into a LAT-deep shift line each RUN cycle.
  - In the cycle the line output is valid, s_sense is compared with it.
  - The compare for vector k happens LAT cycles after vector k is driven.
  - On mismatch: err_count += 1 (saturating). If this is the first mismatch, capture first_fail_idx=k and first_fail_bits.
  - The last compare lands in the final DRAIN cycle; the DONE-state outputs include it.
- IDLE/DONE: n_drive = 0; DONE results hold until the next start.
- pass: combinational done && err_count==0.
- start while busy: ignored.
- stop:
  - From RUN or DRAIN: next state IDLE; n_drive=0, busy=0, done stays 0.
  - err_count and first_fail_* keep their partial values.
  - Delay line is flushed so no further compares occur.
- start and stop in the same cycle: stop wins, state stays IDLE.
- Reset asserted mid-run: immediate async return to reset values; no compare counted.
- Synchronisation: s_sense is used directly with no extra synchroniser. LAT must include any external retiming registers.

Test Plan:
- Ideal loopback model (LAT=2, NVEC=8), mode 0, start -> n_drive 1,2,4,…,0x80 on consecutive cycles; busy 10 cycles; done=1, pass=1, err_count=0.
- Same setup, S4BEG3 stuck at 0, mode 1, NVEC=36 -> 35 vectors mismatch; err_count=35, first_fail_idx=0, first_fail_bits=36'h000800000 (bit 23).
- Mode 2, NVEC=4, model that swaps S2BEG0/S2BEG1 -> every vector where N2MID7≠N2MID6 is counted; err_count matches the reference LFSR count; vector 0 = 36'h5A5A5A5A5.
- Stop asserted in the 3rd RUN cycle -> IDLE next cycle, n_drive=0, done=0, busy=0; a new start gives a clean full run.
- resetn pulsed low mid-DRAIN -> all outputs 0 immediately; start after release runs normally.
- err_count saturation: NVEC=65535, mode 3, S1BEG0 inverted -> err_count=16'hFFFF with no wrap; first_fail_idx=0.
